// File: rtl/al_completion_tracker.sv
// al_completion_tracker
//   Active-list completion tracker that sits downstream of WriteBack. It keeps
//   per-entry allocated/done/flags state for a circular active list. Entries
//   are allocated at dispatch and marked complete by the four writeback ports.
//   Up to COMMIT_WIDTH in-order completed entries retire per cycle. An
//   exception at the head raises a one-cycle flush request.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   flush_i                        recovery flush, empties the list
//   dispatchValid_i/Count_i        allocation request of 0..4 entries
//   alTail_o, alFreeCount_o        next allocation index, free entry count
//   overflowErr_o                  sticky, set by a rejected dispatch
//   wbValidN_i, wbCtrlN_i          writeback port N: {al index, flags}
//   commitValid_o, commitHead_o    thermometer retire mask, index of slot 0
//   commitFlagsN_o                 flags of retire slot N
//   exception_o, exceptionIdx_o    exception at head and its index
module al_completion_tracker #(
    parameter int unsigned AL_DEPTH     = 32,
    parameter int unsigned AL_LOG       = 5,
    parameter int unsigned WB_FLAGS     = 4,
    parameter int unsigned COMMIT_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       dispatchValid_i,
    input  logic [2:0]                 dispatchCount_i,
    output logic [AL_LOG-1:0]          alTail_o,
    output logic [AL_LOG:0]            alFreeCount_o,
    output logic                       overflowErr_o,
    input  logic                       wbValid0_i,
    input  logic                       wbValid1_i,
    input  logic                       wbValid2_i,
    input  logic                       wbValid3_i,
    input  logic [AL_LOG+WB_FLAGS-1:0] wbCtrl0_i,
    input  logic [AL_LOG+WB_FLAGS-1:0] wbCtrl1_i,
    input  logic [AL_LOG+WB_FLAGS-1:0] wbCtrl2_i,
    input  logic [AL_LOG+WB_FLAGS-1:0] wbCtrl3_i,
    output logic [COMMIT_WIDTH-1:0]    commitValid_o,
    output logic [AL_LOG-1:0]          commitHead_o,
    output logic [WB_FLAGS-1:0]        commitFlags0_o,
    output logic [WB_FLAGS-1:0]        commitFlags1_o,
    output logic [WB_FLAGS-1:0]        commitFlags2_o,
    output logic [WB_FLAGS-1:0]        commitFlags3_o,
    output logic                       exception_o,
    output logic [AL_LOG-1:0]          exceptionIdx_o
);

    localparam int unsigned NumWb = 4;

    // Registered state
    logic [AL_LOG-1:0]   r_head;
    logic [AL_LOG-1:0]   r_tail;
    logic [AL_LOG:0]     r_count;
    logic [AL_DEPTH-1:0] r_alloc;
    logic [AL_DEPTH-1:0] r_done;
    logic [WB_FLAGS-1:0] r_flags [AL_DEPTH];
    logic                r_overflow;

    // Next state
    logic [AL_LOG-1:0]   w_head_d;
    logic [AL_LOG-1:0]   w_tail_d;
    logic [AL_LOG:0]     w_count_d;
    logic [AL_DEPTH-1:0] w_alloc_d;
    logic [AL_DEPTH-1:0] w_done_d;
    logic [WB_FLAGS-1:0] w_flags_d [AL_DEPTH];
    logic                w_overflow_d;

    // Writeback ports gathered into arrays
    logic [NumWb-1:0]                 w_wb_valid;
    logic [AL_LOG+WB_FLAGS-1:0]       w_wb_ctrl [NumWb];
    logic [AL_LOG-1:0]                w_wb_idx  [NumWb];
    logic [WB_FLAGS-1:0]              w_wb_flg  [NumWb];

    assign w_wb_valid   = {wbValid3_i, wbValid2_i, wbValid1_i, wbValid0_i};
    assign w_wb_ctrl[0] = wbCtrl0_i;
    assign w_wb_ctrl[1] = wbCtrl1_i;
    assign w_wb_ctrl[2] = wbCtrl2_i;
    assign w_wb_ctrl[3] = wbCtrl3_i;

    for (genvar p = 0; p < NumWb; p++) begin : g_wb_split
        assign w_wb_idx[p] = w_wb_ctrl[p][AL_LOG+WB_FLAGS-1 -: AL_LOG];
        assign w_wb_flg[p] = w_wb_ctrl[p][WB_FLAGS-1:0];
    end

    // Commit scan, purely from registered state
    logic [AL_LOG-1:0]       w_slot_idx [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0] w_commit;
    logic [2:0]              w_commit_cnt;
    logic                    w_run;
    logic                    w_exc;

    for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_slot
        assign w_slot_idx[k] = r_head + AL_LOG'(k);
    end

    always_comb begin
        w_commit     = '0;
        w_commit_cnt = '0;
        w_run        = 1'b1;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            // count bound stops the scan at the tail even when the list is full
            if (w_run && (k < int'(r_count)) && r_alloc[w_slot_idx[k]] &&
                r_done[w_slot_idx[k]] && !r_flags[w_slot_idx[k]][0]) begin
                w_commit[k]  = 1'b1;
                w_commit_cnt = w_commit_cnt + 3'd1;
            end else begin
                w_run = 1'b0;
            end
        end
    end

    assign w_exc = (r_count != '0) && r_alloc[r_head] && r_done[r_head] && r_flags[r_head][0];

    // Dispatch admission uses the free count before this cycle's commit
    logic [AL_LOG:0] w_free;
    logic            w_kill;
    logic            w_req_bad;
    logic            w_disp_ok;

    assign w_free    = (AL_LOG+1)'(AL_DEPTH) - r_count;
    assign w_kill    = flush_i | w_exc;
    assign w_req_bad = (dispatchCount_i > 3'd4) || ((AL_LOG+1)'(dispatchCount_i) > w_free);
    assign w_disp_ok = dispatchValid_i && !w_kill && !w_req_bad;

    always_comb begin
        w_head_d     = r_head;
        w_tail_d     = r_tail;
        w_count_d    = r_count;
        w_alloc_d    = r_alloc;
        w_done_d     = r_done;
        w_flags_d    = r_flags;
        w_overflow_d = r_overflow | (dispatchValid_i && !w_kill && w_req_bad);

        if (w_kill) begin
            // Empty the list but keep the tail so indices stay monotonic
            w_alloc_d = '0;
            w_done_d  = '0;
            w_head_d  = r_tail;
            w_count_d = '0;
        end else begin
            // Later ports override earlier ones on an index collision
            for (int p = 0; p < NumWb; p++) begin
                if (w_wb_valid[p] && r_alloc[w_wb_idx[p]]) begin
                    w_done_d[w_wb_idx[p]]  = 1'b1;
                    w_flags_d[w_wb_idx[p]] = w_wb_flg[p];
                end
            end
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (w_commit[k]) begin
                    w_alloc_d[w_slot_idx[k]] = 1'b0;
                    w_done_d[w_slot_idx[k]]  = 1'b0;
                end
            end
            if (w_disp_ok) begin
                for (int k = 0; k < 4; k++) begin
                    if (k < int'(dispatchCount_i)) begin
                        w_alloc_d[r_tail + AL_LOG'(k)] = 1'b1;
                        w_done_d[r_tail + AL_LOG'(k)]  = 1'b0;
                    end
                end
                w_tail_d = r_tail + AL_LOG'(dispatchCount_i);
            end
            w_head_d  = r_head + AL_LOG'(w_commit_cnt);
            w_count_d = r_count + (w_disp_ok ? (AL_LOG+1)'(dispatchCount_i) : '0)
                        - (AL_LOG+1)'(w_commit_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_alloc    <= '0;
            r_done     <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < AL_DEPTH; i++) begin
                r_flags[i] <= '0;
            end
        end else begin
            r_head     <= w_head_d;
            r_tail     <= w_tail_d;
            r_count    <= w_count_d;
            r_alloc    <= w_alloc_d;
            r_done     <= w_done_d;
            r_overflow <= w_overflow_d;
            for (int i = 0; i < AL_DEPTH; i++) begin
                r_flags[i] <= w_flags_d[i];
            end
        end
    end

    assign alTail_o       = r_tail;
    assign alFreeCount_o  = w_free;
    assign overflowErr_o  = r_overflow;
    assign commitValid_o  = w_commit;
    assign commitHead_o   = r_head;
    assign commitFlags0_o = r_flags[w_slot_idx[0]];
    assign commitFlags1_o = r_flags[w_slot_idx[1]];
    assign commitFlags2_o = r_flags[w_slot_idx[2]];
    assign commitFlags3_o = r_flags[w_slot_idx[3]];
    assign exception_o    = w_exc;
    assign exceptionIdx_o = w_exc ? r_head : '0;

endmodule

// File: doc/al_completion_tracker.md
Name: al_completion_tracker

Overview:
- Active-list completion tracker that sits directly downstream of the WriteBack stage.
- Consumes the four writeback completion ports (valid plus ctrlFU word = active-list index and writeback flags).
- Tracks per-entry done and flags state for a circular active list, allocates entries at dispatch, and retires up to four in-order completed entries per cycle.
- Detects an exception at the head and raises a flush request.

Parameters:
- AL_DEPTH, 32, active-list entries; power of two.
- AL_LOG, 5, log2(AL_DEPTH).
- WB_FLAGS, 4, writeback flag bits per entry; bit0 = exception, bit1 = mispredict, others pass through.
- COMMIT_WIDTH, 4, maximum retirements per cycle; fixed at 4.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- flush_i  in  1  recovery flush; empties the list.
- dispatchValid_i  in  1  allocation request.
- dispatchCount_i  in  3  entries to allocate, 0..4.
- alTail_o  out  AL_LOG  index of the first entry that the next allocation receives.
- alFreeCount_o  out  AL_LOG+1  free entries.
- overflowErr_o  out  1  sticky; set when a request is rejected.
- wbValid0_i..wbValid3_i  in  1 each  writeback port valid.
- wbCtrl0_i..wbCtrl3_i  in  AL_LOG+WB_FLAGS each  {al index, flags}; index is in the upper bits.
- commitValid_o  out  4  thermometer mask of retiring slots.
- commitHead_o  out  AL_LOG  index of commit slot 0.
- commitFlags0_o..commitFlags3_o  out  WB_FLAGS each  flags of the retiring entries.
- exception_o  out  1  exception at head; one-cycle pulse.
- exceptionIdx_o  out  AL_LOG  index of the excepting entry.

Behaviour:
- Reset is synchronous and active-high, and applies on any cycle, including mid-operation. On reset:
  - head = tail = 0 and count = 0.
  - All done bits and flags are cleared.
  - overflowErr_o = 0.
  - All outputs are 0, except alFreeCount_o = AL_DEPTH.
- State:
  - head and tail pointers, each AL_LOG bits, wrapping modulo AL_DEPTH.
  - count, AL_LOG+1 bits, which distinguishes full (count = AL_DEPTH) from empty (count = 0).
- Dispatch:
  - Accepted when dispatchValid_i = 1 and dispatchCount_i <= free count.
  - On acceptance, entries tail..tail+n-1 have done cleared and allocated set, and tail advances by n at the edge.
  - A request with dispatchCount_i > free count allocates nothing and sets overflowErr_o, which stays set until reset.
  - A request with dispatchCount_i > 4 is treated as overflow.
- Writeback:
  - wbValidN_i = 1 sets done[index] and flags[index] at the edge.
  - A writeback to an unallocated index is ignored.
  - Two ports writing the same index in one cycle: done is set, and flags come from the highest-numbered port.
  - There is no ordering requirement between ports.
- Commit is combinational from registered state, so an entry completed in cycle t can retire in cycle t+1.
  - Slot k (k = 0..3) retires if entry head+k is allocated and done, entry head+k has flags bit0 = 0, and all slots j < k retire.
  - The scan wraps modulo AL_DEPTH and stops at the tail.
  - commitValid_o is a thermometer mask (0000, 0001, 0011, 0111, 1111).
  - head advances by the popcount of commitValid_o at the edge.
  - commitFlagsK_o = flags[head+k].
- Exception:
  - Raised when entry head is allocated and done with flags bit0 = 1.
  - In that cycle, commitValid_o = 0, exception_o = 1 and exceptionIdx_o = head.
  - At the next edge the list empties: head = tail, count = 0, all allocated and done bits cleared.
  - Any dispatch in that cycle is dropped.
- Mispredict (flags bit1) does not block commit; it is only reported in commitFlags.
- flush_i:
  - At the next edge the list empties as for an exception; the tail is kept and head is set to tail.
  - Simultaneous dispatch and writeback are ignored.
  - flush_i has priority over everything except reset.
- Simultaneous dispatch and commit: count_next = count + dispatched - committed. Free count is sampled before the cycle's commit, which is conservative.
- alFreeCount_o = AL_DEPTH - count; it is registered state, with no combinational path from the inputs.

Test Plan:
- Reset, dispatch 4, writeback indices 0..3 on ports 0..3 in one cycle, all flags 0:
  - next cycle commitValid_o = 1111 and commitHead_o = 0;
  - cycle after that, alFreeCount_o = 32 and alTail_o = 4.
- Dispatch 3; writeback index 1, then index 0 one cycle later, index 2 never:
  - commitValid_o stays 0000 until index 0 is done, then 0011;
  - entry 2 remains pending.
- Dispatch 2; writeback index 0 with flags 0001:
  - exception_o = 1, exceptionIdx_o = 0, commitValid_o = 0000;
  - next cycle alFreeCount_o = 32.
- Wrap: advance head and tail to 30, dispatch 4 (entries 30, 31, 0, 1), complete all:
  - commitValid_o = 1111 and commitHead_o = 30;
  - afterwards head = 2.
- Fill to 32 (alFreeCount_o = 0), then dispatch 1:
  - no allocation, overflowErr_o = 1 and stays 1;
  - count unchanged.
- Duplicate writeback of index 5 on port 0 (flags 0010) and port 3 (flags 0000):
  - commitFlags shows 0000 for that entry.
- Reset asserted mid-stream:
  - all outputs return to reset values at the next edge.
